// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: merges ALU (A, priority) and load-unit (B) write-backs into one register-file write port.
// Optional forwarding of the youngest pending data to the read ports when WB_FORWARD_EN is defined.
module regfile_wb_buffer #(
    parameter int BITSIZE  = 64,
    parameter int REGSIZE  = 32,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 31,
    localparam int SELW = $clog2(REGSIZE),
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    input  logic [SELW-1:0]    a_sel,
    input  logic [BITSIZE-1:0] a_data,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [SELW-1:0]    b_sel,
    input  logic [BITSIZE-1:0] b_data,
    output logic               b_ready,
    output logic               WriteEnable,
    output logic [SELW-1:0]    WriteSelect,
    output logic [BITSIZE-1:0] WriteData,
    input  logic [SELW-1:0]    ReadSelect1,
    input  logic [SELW-1:0]    ReadSelect2,
    output logic               hazard1,
    output logic               hazard2,
    output logic [CW-1:0]      count
`ifdef WB_FORWARD_EN
    ,
    output logic [BITSIZE-1:0] fwd_data1,
    output logic [BITSIZE-1:0] fwd_data2
`endif
);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [SELW-1:0] ZSEL = SELW'(ZERO_REG);

    logic [SELW-1:0]    sel_q  [DEPTH];
    logic [BITSIZE-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PW-1:0]      rd_ptr, wr_ptr, b_slot;
    logic               a_enq, b_enq, deq;

    // Ready looks only at start-of-cycle occupancy; B must leave room for A
    assign a_ready = count < FULL;
    assign b_ready = a_valid ? (count <= FULL - CW'(2)) : (count < FULL);
    assign a_enq   = a_valid && a_ready && a_sel != ZSEL;
    assign b_enq   = b_valid && b_ready && b_sel != ZSEL;
    assign deq     = count != '0;
    assign b_slot  = wr_ptr + PW'(a_enq);

    assign WriteEnable = deq;
    assign WriteSelect = deq ? sel_q[rd_ptr] : '0;
    assign WriteData   = deq ? data_q[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sel_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (deq) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            if (a_enq) begin
                sel_q[wr_ptr]   <= a_sel;
                data_q[wr_ptr]  <= a_data;
                valid_q[wr_ptr] <= 1'b1;
            end
            if (b_enq) begin
                sel_q[b_slot]   <= b_sel;
                data_q[b_slot]  <= b_data;
                valid_q[b_slot] <= 1'b1;
            end
            wr_ptr <= wr_ptr + PW'(a_enq) + PW'(b_enq);
            count  <= count + CW'(a_enq) + CW'(b_enq) - CW'(deq);
        end
    end

    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hazard1 = hazard1 | (valid_q[i] && sel_q[i] == ReadSelect1 && ReadSelect1 != ZSEL);
            hazard2 = hazard2 | (valid_q[i] && sel_q[i] == ReadSelect2 && ReadSelect2 != ZSEL);
        end
    end

`ifdef WB_FORWARD_EN
    // Walk oldest to youngest so the last match is the youngest pending value
    always_comb begin
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[rd_ptr + PW'(i)] && sel_q[rd_ptr + PW'(i)] == ReadSelect1)
                fwd_data1 = data_q[rd_ptr + PW'(i)];
            if (valid_q[rd_ptr + PW'(i)] && sel_q[rd_ptr + PW'(i)] == ReadSelect2)
                fwd_data2 = data_q[rd_ptr + PW'(i)];
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wb_buffer.sv
// tb_regfile_wb_buffer: table-driven per-cycle vectors plus reset and duplicate-register sequences.
module tb_regfile_wb_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_sel, b_sel, ReadSelect1, ReadSelect2, WriteSelect;
    logic [63:0] a_data, b_data, WriteData;
    logic        WriteEnable, hazard1, hazard2;
    logic [2:0]  count;
`ifdef WB_FORWARD_EN
    logic [63:0] fwd_data1, fwd_data2;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_buffer dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready),
        .WriteEnable(WriteEnable), .WriteSelect(WriteSelect), .WriteData(WriteData),
        .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2),
        .hazard1(hazard1), .hazard2(hazard2), .count(count)
`ifdef WB_FORWARD_EN
        , .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
    );

    typedef struct {
        logic av; logic [4:0] asel; logic [63:0] adata;
        logic bv; logic [4:0] bsel; logic [63:0] bdata;
        logic [4:0] r1, r2;
        logic ar, br, we; logic [4:0] ws; logic [63:0] wd;
        logic h1, h2; logic [2:0] cnt;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(input logic av, input logic [4:0] asel, input logic [63:0] adata,
                                input logic bv, input logic [4:0] bsel, input logic [63:0] bdata,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic ar, input logic br, input logic we,
                                input logic [4:0] ws, input logic [63:0] wd,
                                input logic h1, input logic h2, input logic [2:0] cnt);
        vec_t v;
        v.av = av; v.asel = asel; v.adata = adata;
        v.bv = bv; v.bsel = bsel; v.bdata = bdata;
        v.r1 = r1; v.r2 = r2;
        v.ar = ar; v.br = br; v.we = we; v.ws = ws; v.wd = wd;
        v.h1 = h1; v.h2 = h2; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] asel, input logic [63:0] adata,
                         input logic bv, input logic [4:0] bsel, input logic [63:0] bdata,
                         input logic [4:0] r1, input logic [4:0] r2);
        a_valid = av; a_sel = asel; a_data = adata;
        b_valid = bv; b_sel = bsel; b_data = bdata;
        ReadSelect1 = r1; ReadSelect2 = r2;
    endtask

    initial begin
        // av asel adata   bv bsel bdata    r1  r2   ar br we ws  wd      h1 h2 cnt
        vt[0]  = mk(0, 0, 0,     0, 0, 0,      0, 0,   1, 1, 0, 0, 0,      0, 0, 0);
        vt[1]  = mk(1, 4, 'hF,   0, 0, 0,      4, 0,   1, 1, 0, 0, 0,      0, 0, 0);
        vt[2]  = mk(0, 0, 0,     0, 0, 0,      4, 5,   1, 1, 1, 4, 'hF,    1, 0, 1);
        vt[3]  = mk(0, 0, 0,     0, 0, 0,      4, 5,   1, 1, 0, 0, 0,      0, 0, 0);
        vt[4]  = mk(1, 2, 'hAA,  1, 3, 'hBB,   2, 3,   1, 1, 0, 0, 0,      0, 0, 0);
        vt[5]  = mk(0, 0, 0,     0, 0, 0,      2, 3,   1, 1, 1, 2, 'hAA,   1, 1, 2);
        vt[6]  = mk(0, 0, 0,     0, 0, 0,      2, 3,   1, 1, 1, 3, 'hBB,   0, 1, 1);
        vt[7]  = mk(1, 31, 'h55, 0, 0, 0,      31, 31, 1, 1, 0, 0, 0,      0, 0, 0);
        vt[8]  = mk(0, 0, 0,     0, 0, 0,      31, 0,  1, 1, 0, 0, 0,      0, 0, 0);
        vt[9]  = mk(1, 5, 'h1,   1, 5, 'h2,    5, 0,   1, 1, 0, 0, 0,      0, 0, 0);
        vt[10] = mk(1, 6, 'h66,  1, 7, 'h77,   5, 7,   1, 1, 1, 5, 'h1,    1, 0, 2);
        vt[11] = mk(1, 8, 'h88,  1, 9, 'h99,   5, 9,   1, 0, 1, 5, 'h2,    1, 0, 3);
        vt[12] = mk(0, 0, 0,     1, 10, 'hA0,  5, 8,   1, 1, 1, 6, 'h66,   0, 1, 3);
        vt[13] = mk(0, 0, 0,     0, 0, 0,      7, 10,  1, 1, 1, 7, 'h77,   1, 1, 3);
        vt[14] = mk(0, 0, 0,     0, 0, 0,      8, 10,  1, 1, 1, 8, 'h88,   1, 1, 2);
        vt[15] = mk(0, 0, 0,     0, 0, 0,      8, 10,  1, 1, 1, 10, 'hA0,  0, 1, 1);
        vt[16] = mk(1, 31, 'h55, 1, 12, 'hC,   12, 31, 1, 1, 0, 0, 0,      0, 0, 0);
        vt[17] = mk(0, 0, 0,     0, 0, 0,      12, 31, 1, 1, 1, 12, 'hC,   1, 0, 1);
        vt[18] = mk(0, 0, 0,     0, 0, 0,      12, 31, 1, 1, 0, 0, 0,      0, 0, 0);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_count", 64'(count), 0);
        chk("rst_we", 64'(WriteEnable), 0);
        chk("rst_ws", 64'(WriteSelect), 0);
        chk("rst_wd", WriteData, 0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vt[i].av, vt[i].asel, vt[i].adata, vt[i].bv, vt[i].bsel, vt[i].bdata, vt[i].r1, vt[i].r2);
            #1;
            chk($sformatf("v%0d_a_ready", i), 64'(a_ready), 64'(vt[i].ar));
            chk($sformatf("v%0d_b_ready", i), 64'(b_ready), 64'(vt[i].br));
            chk($sformatf("v%0d_we", i), 64'(WriteEnable), 64'(vt[i].we));
            chk($sformatf("v%0d_ws", i), 64'(WriteSelect), 64'(vt[i].ws));
            chk($sformatf("v%0d_wd", i), WriteData, vt[i].wd);
            chk($sformatf("v%0d_hazard1", i), 64'(hazard1), 64'(vt[i].h1));
            chk($sformatf("v%0d_hazard2", i), 64'(hazard2), 64'(vt[i].h2));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].cnt));
        end

        // Asynchronous reset with three entries in flight
        @(negedge clk) drive(1, 1, 'h11, 1, 2, 'h22, 0, 0);
        @(negedge clk) drive(1, 3, 'h33, 1, 4, 'h44, 0, 0);
        @(negedge clk) drive(0, 0, 0, 0, 0, 0, 3, 4);
        #1;
        chk("pre_rst_count", 64'(count), 3);
        chk("pre_rst_hazard1", 64'(hazard1), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_we", 64'(WriteEnable), 0);
        chk("mid_rst_ws", 64'(WriteSelect), 0);
        chk("mid_rst_hazard1", 64'(hazard1), 0);
        chk("mid_rst_hazard2", 64'(hazard2), 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) #1;
        chk("post_rst_count", 64'(count), 0);
        chk("post_rst_we", 64'(WriteEnable), 0);

        // Duplicate destination: both writes reach the port in order, youngest forwarded
        @(negedge clk) drive(1, 5, 'h1, 1, 5, 'h2, 5, 0);
        @(negedge clk) drive(0, 0, 0, 0, 0, 0, 5, 0);
        #1;
        chk("dup_count0", 64'(count), 2);
        chk("dup_hazard1_0", 64'(hazard1), 1);
        chk("dup_wd0", WriteData, 'h1);
`ifdef WB_FORWARD_EN
        chk("dup_fwd0", fwd_data1, 'h2);
`endif
        @(negedge clk) #1;
        chk("dup_count1", 64'(count), 1);
        chk("dup_hazard1_1", 64'(hazard1), 1);
        chk("dup_wd1", WriteData, 'h2);
`ifdef WB_FORWARD_EN
        chk("dup_fwd1", fwd_data1, 'h2);
`endif
        @(negedge clk) #1;
        chk("dup_count2", 64'(count), 0);
        chk("dup_hazard1_2", 64'(hazard1), 0);
`ifdef WB_FORWARD_EN
        chk("dup_fwd2", fwd_data1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
